// File: rtl/sys_arr_psum_deskew.sv
// sys_arr_psum_deskew
//   Output deskew and buffering stage for the systolic array. The last PE row
//   emits partial sums staggered in time: lane k of a result row appears k
//   cycles after lane 0. Each lane is delayed so that the whole row lines up
//   in one cycle. Aligned rows, tagged with end-of-tile framing, are queued in
//   a small FIFO and handed downstream with a valid/ready handshake. The array
//   cannot be stalled, so a row arriving at a full FIFO is dropped and a
//   sticky overflow flag is raised.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset, clears all control and pipeline state
//   in_valid    lane 0 of a result row is on psum_in this cycle
//   psum_in     N lanes of PSUM_BW signed bits, lane k at [k*PSUM_BW +: PSUM_BW]
//   out_valid   FIFO head holds an aligned row
//   out_ready   downstream accepts the head when out_valid && out_ready
//   out_data    aligned row (same lane packing), zero when out_valid is low
//   out_last    head row is the final row of its tile, zero when out_valid is low
//   fifo_count  current FIFO occupancy
//   overflow    sticky flag: a row was dropped on a full FIFO
//   ovf_clr     synchronous clear of overflow (a coincident drop wins)
module sys_arr_psum_deskew #(
  parameter int N          = 8,
  parameter int PSUM_BW    = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [N*PSUM_BW-1:0]            psum_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N*PSUM_BW-1:0]            out_data,
  output logic                            out_last,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = N * PSUM_BW;

  // ---------------------------------------------------------------------------
  // Stage p0: per-lane deskew. Lane k is delayed N-1-k cycles so every lane of
  // a row lands in the same cycle as lane N-1, which is used straight from the
  // input.
  // ---------------------------------------------------------------------------
  logic [ROW_W-1:0] row_p0;

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int D = N - 1 - k;
    if (D == 0) begin : g_pass
      assign row_p0[k*PSUM_BW +: PSUM_BW] = psum_in[k*PSUM_BW +: PSUM_BW];
    end else begin : g_dly
      logic signed [PSUM_BW-1:0] dly_p0 [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) dly_p0[i] <= '0;
        end else begin
          dly_p0[0] <= psum_in[k*PSUM_BW +: PSUM_BW];
          for (int i = 1; i < D; i++) dly_p0[i] <= dly_p0[i-1];
        end
      end
      assign row_p0[k*PSUM_BW +: PSUM_BW] = dly_p0[D-1];
    end
  end

  // in_valid marks lane 0 only; delaying it N-1 cycles gives the aligned-valid.
  logic [N-2:0] vld_dly_p0;
  logic         vld_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_dly_p0 <= '0;
    end else begin
      vld_dly_p0[0] <= in_valid;
      for (int i = 1; i < N - 1; i++) vld_dly_p0[i] <= vld_dly_p0[i-1];
    end
  end

  assign vld_p0 = vld_dly_p0[N-2];

  // Tile framing: every aligned row advances the counter, including dropped
  // rows, so a drop never shifts the position of the last-row tag.
  logic [RW-1:0] row_cnt;
  logic          last_p0;

  assign last_p0 = (row_cnt == RW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (vld_p0) begin
      row_cnt <= last_p0 ? '0 : row_cnt + RW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: aligned-row FIFO. A read frees a slot on the same edge, so a
  // full FIFO still accepts a row when the head is popped simultaneously.
  // ---------------------------------------------------------------------------
  logic [ROW_W:0]  mem_p1 [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            do_read;
  logic            do_write;
  logic            drop;
  logic            ovf_q;
  logic [ROW_W:0]  head_p1;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_read  = out_valid && out_ready;
  assign do_write = vld_p0 && (!full || do_read);
  assign drop     = vld_p0 && full && !do_read;

  // Storage carries no reset: its contents are only observed through the
  // count-qualified output mux.
  always_ff @(posedge clk) begin
    if (do_write) mem_p1[wr_ptr] <= {last_p0, row_p0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output: head of FIFO, driven only from registered state.
  // ---------------------------------------------------------------------------
  assign head_p1    = mem_p1[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? head_p1[ROW_W-1:0] : '0;
  assign out_last   = out_valid ? head_p1[ROW_W] : 1'b0;
  assign fifo_count = count;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sys_arr_psum_deskew.sv
// tb_sys_arr_psum_deskew
//   Directed bench for sys_arr_psum_deskew. The stimulus side skews each row
//   across the lanes as the array would and pushes the expected aligned row
//   (with its last tag) into a scoreboard queue; a monitor pops and compares
//   on every output handshake. Level checks cover occupancy, overflow and reset.
module tb_sys_arr_psum_deskew;

  localparam int N     = 8;
  localparam int BW    = 19;
  localparam int DEPTH = 4;
  localparam int ROW_W = N * BW;

  typedef logic [ROW_W-1:0] row_t;
  typedef struct packed {
    row_t data;
    logic last;
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic [ROW_W-1:0]          psum_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [ROW_W-1:0]          out_data;
  logic                      out_last;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      overflow;
  logic                      ovf_clr;

  sys_arr_psum_deskew #(.N(N), .PSUM_BW(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  bit   hv [N];
  row_t hr [N];
  int   tcnt = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk_row(input int base);
    row_t r;
    for (int k = 0; k < N; k++) r[k*BW +: BW] = BW'(base + k);
    return r;
  endfunction

  // Monitor: one comparison per accepted output row, idle outputs must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_row", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("row_data", out_data, e.data);
          check("row_last", out_last, e.last);
        end
      end
      if (!out_valid) begin
        check("idle_data", out_data, '0);
        check("idle_last", out_last, 1'b0);
      end
    end
  end

  // One clock of stimulus. Lane k shows the row issued k cycles earlier; lanes
  // with no row in flight carry noise, since only lane 0 is qualified.
  task automatic cycle(input bit v, input row_t r, input bit push);
    exp_t e;
    for (int k = N - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hr[k] = hr[k-1];
    end
    hv[0] = v;
    hr[0] = r;
    if (v) begin
      e.data = r;
      e.last = (tcnt == N - 1);
      if (push) sb.push_back(e);
      tcnt = (tcnt + 1) % N;
    end
    for (int k = 0; k < N; k++)
      psum_in[k*BW +: BW] = hv[k] ? hr[k][k*BW +: BW] : BW'($urandom);
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) idle(1);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    for (int k = 0; k < N; k++) hv[k] = 1'b0;
    tcnt = 0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data, '0);
    check("rst_out_last",  out_last, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow",  overflow, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    row_t r;
    rst       = 1'b0;
    in_valid  = 1'b0;
    psum_in   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    do_reset();

    // Single row: lanes 100..107, held in the FIFO until released.
    out_ready = 1'b0;
    cycle(1'b1, mk_row(100), 1'b1);
    idle(6);
    check("lat_not_yet", out_valid, 1'b0);
    idle(1);
    check("lat_valid", out_valid, 1'b1);
    check("single_count", fifo_count, 1);
    idle(2);
    check("single_hold", fifo_count, 1);
    out_ready = 1'b1;
    idle(1);
    check("single_popped", fifo_count, 0);
    drain(10);

    // Full tile streaming with negative lane values.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      r = mk_row(i * 16);
      if (i == 1) r[3*BW +: BW] = BW'(-1);
      if (i == 5) r[6*BW +: BW] = BW'(-262144);
      cycle(1'b1, r, 1'b1);
    end
    idle(12);
    check("stream_count", fifo_count, 0);
    check("stream_ovf", overflow, 1'b0);
    drain(10);

    // Backpressure: six rows into a four-deep FIFO, rows 4 and 5 dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b1, mk_row(200 + i * 16), (i < 4));
    idle(10);
    check("bp_count", fifo_count, 4);
    check("bp_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    drain(20);
    check("bp_empty", fifo_count, 0);
    check("bp_ovf_sticky", overflow, 1'b1);
    // Rows 6,7 close the tile, then a full fresh tile.
    for (int i = 0; i < 10; i++) cycle(1'b1, mk_row(1000 + i * 8), 1'b1);
    drain(20);

    // Full FIFO with a pop on the same edge the fifth row is written.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      out_ready = (c == 11);
      if (c < 5) cycle(1'b1, mk_row(300 + c * 16), 1'b1);
      else       idle(1);
    end
    out_ready = 1'b0;
    check("fullpop_count", fifo_count, 4);
    check("fullpop_ovf", overflow, 1'b0);
    out_ready = 1'b1;
    drain(20);

    // Overflow clear, then clear coincident with a drop.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, mk_row(400 + i * 16), (i < 4));
    idle(7);
    check("clr_ovf_set", overflow, 1'b1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("clr_ovf_cleared", overflow, 1'b0);
    cycle(1'b1, mk_row(500), 1'b0);
    idle(6);
    check("clr_before_drop", overflow, 1'b0);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("clr_drop_wins", overflow, 1'b1);
    check("clr_count", fifo_count, 4);
    out_ready = 1'b1;
    drain(20);

    // Reset while a row is inside the deskew pipeline.
    do_reset();
    out_ready = 1'b1;
    cycle(1'b1, mk_row(600), 1'b0);
    idle(2);
    do_reset();
    idle(12);
    check("midrst_no_valid", out_valid, 1'b0);
    check("midrst_count", fifo_count, 0);
    for (int i = 0; i < N; i++) cycle(1'b1, mk_row(700 + i * 16), 1'b1);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
